srff_cell: RTL and testbench
============================

Name: srff_cell

Overview:
- Clocked set/reset flip-flop (vector of SR storage bits) with synchronous active-low clear and preset and a clock enable.
- Used by control FSMs to latch one-shot requests (e.g. a start pulse). The bit stays set until the FSM issues a reset pulse.
- Pure sequential storage. No combinational path from any input to q.

Parameters:
- WIDTH, 1, number of independent SR bits. Legal range 1..64.
- INIT, 0, power-up value of q (WIDTH bits, replicated if given as 0/1).
- BOTH_MODE, 0, action when s and r are both 1 on a bit: 0 = hold, 1 = set wins, 2 = reset wins, 3 = toggle.

Ports:
- clk, input, 1, rising-edge clock. All state changes occur on this edge.
- clrn, input, 1, reset: synchronous, active-low. Forces q to 0. Highest priority.
- prn, input, 1, synchronous active-low preset. Forces q to all ones. Second priority.
- ena, input, 1, clock enable, active-high. When 0, q holds (s/r ignored).
- s, input, WIDTH, per-bit set request, active-high.
- r, input, WIDTH, per-bit reset request, active-high.
- q, output, WIDTH, registered state.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, clrn).
- Power-up: q = INIT (initial value, not a reset). No reset is required for correct first use.
- On each rising clk edge, evaluate in this priority:
  - clrn = 0: q = 0. prn, ena, s and r are ignored.
  - else if prn = 0: q = all ones. ena, s and r are ignored.
  - else if ena = 0: q holds.
  - else, per bit i:
    - s=0, r=0: hold.
    - s=1, r=0: q[i]=1.
    - s=0, r=1: q[i]=0.
    - s=1, r=1: action per BOTH_MODE.
- Latency: a request sampled on edge N is visible on q after edge N (one-cycle register latency). q never changes between edges.
- Pulse capture: a single-cycle s pulse leaves q=1 indefinitely until r (or clrn) is applied. Repeated s while q=1 has no effect.
- clrn and prn are not asynchronous. Their assertion between edges has no effect until the next edge.
- Integration: unused clrn, prn and ena must be tied to 1. The block is specified only for 0/1 inputs.
- Bits are fully independent. No cross-bit interaction.
- Illegal BOTH_MODE values (>3) behave as hold.

Test Plan:
- Power-up, no stimulus, clrn=prn=ena=1, s=r=0 for 5 cycles -> q stays INIT (0).
- s=1 for one cycle, then s=0 for 10 cycles -> q=1 from the edge after the s pulse and holds 1 for all 10 cycles. Then r=1 for one cycle -> q=0 after that edge and remains 0.
- BOTH_MODE sweep with q=0 then q=1, s=r=1 for one cycle:
  - mode 0 -> q unchanged.
  - mode 1 -> q=1.
  - mode 2 -> q=0.
  - mode 3 -> q inverts on each cycle s=r=1 is held (0,1,0,1 over 4 cycles).
- Priority check, all inputs active simultaneously:
  - q=1, clrn=0, prn=0, s=1 -> q=0.
  - clrn=1, prn=0, r=1 -> q=1.
  - Pulse clrn low between edges only (glitch not spanning an edge) -> q unchanged.
- Enable: ena=0 with s=1 for 3 cycles -> q holds 0. Raise ena=1 with s still 1 -> q=1 after the next edge.
- WIDTH=4: s=4'b0101, r=4'b1000, from q=4'b1000 -> q=4'b0101. Then s=4'b0010, r=4'b0001 -> q=4'b0110.

Source files
------------

// File: rtl/srff_cell_if.sv
// Bundle of the SR storage signals shared by the SR flip-flop and whoever
// drives it: the set/reset request vectors, the preset and enable strobes,
// and the registered state coming back.
interface srff_cell_if #(
    parameter int WIDTH = 1
);
    logic             prn;  // synchronous preset, active-low
    logic             ena;  // clock enable, active-high
    logic [WIDTH-1:0] s;    // per-bit set request
    logic [WIDTH-1:0] r;    // per-bit reset request
    logic [WIDTH-1:0] q;    // registered state

    // Controller side: issues requests and observes the state.
    modport master (
        output prn,
        output ena,
        output s,
        output r,
        input  q
    );

    // Storage side: consumes requests and presents the state.
    modport slave (
        input  prn,
        input  ena,
        input  s,
        input  r,
        output q
    );
endinterface

// File: rtl/srff_cell.sv
// Vector of independent clocked SR storage bits.
// Priority on every rising edge: clear (clrn low) > preset (prn low) >
// enable low (hold) > per-bit set/reset. The s=r=1 case is resolved by
// BOTH_MODE: 0 hold, 1 set wins, 2 reset wins, 3 toggle, anything else hold.
// q comes straight from a register, so no input reaches it combinationally.
module srff_cell #(
    parameter int          WIDTH     = 1,
    // Power-up value of q. The value 1 is replicated to all ones so a
    // single-bit style "start set" works for any WIDTH.
    parameter logic [63:0] INIT      = 64'd0,
    parameter int          BOTH_MODE = 0
) (
    input  logic        clk,
    input  logic        clrn,
    srff_cell_if.slave  bus
);

    localparam logic [WIDTH-1:0] INIT_VEC =
        (INIT == 64'd1) ? {WIDTH{1'b1}} : INIT[WIDTH-1:0];

    // Power-up content of the storage; no reset is needed before first use.
    logic [WIDTH-1:0] r_q = INIT_VEC;

    logic [WIDTH-1:0] w_both_next;  // per-bit value when s=r=1
    logic [WIDTH-1:0] w_req_next;   // per-bit value from the s/r request
    logic [WIDTH-1:0] w_q_next;     // value loaded on the next edge

    // Each bit resolves its own request; there is no cross-bit interaction.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (BOTH_MODE == 1) begin : g_set_wins
            assign w_both_next[gi] = 1'b1;
        end else if (BOTH_MODE == 2) begin : g_reset_wins
            assign w_both_next[gi] = 1'b0;
        end else if (BOTH_MODE == 3) begin : g_toggle
            assign w_both_next[gi] = ~r_q[gi];
        end else begin : g_hold
            // Mode 0 and any out-of-range mode keep the bit as it is.
            assign w_both_next[gi] = r_q[gi];
        end

        assign w_req_next[gi] =
            ( bus.s[gi] &&  bus.r[gi]) ? w_both_next[gi] :
            ( bus.s[gi] && !bus.r[gi]) ? 1'b1            :
            (!bus.s[gi] &&  bus.r[gi]) ? 1'b0            :
                                         r_q[gi];
    end

    // Apply clear, preset and enable on top of the per-bit request.
    always_comb begin
        w_q_next = r_q;
        if (!clrn) begin
            w_q_next = '0;
        end else if (!bus.prn) begin
            w_q_next = '1;
        end else if (bus.ena) begin
            w_q_next = w_req_next;
        end
    end

    // State register; clrn and prn only act on this edge.
    always_ff @(posedge clk) begin
        r_q <= w_q_next;
    end

    assign bus.q = r_q;

endmodule

// File: tb/tb_srff_cell.sv
// Bench for srff_cell: four WIDTH=4 instances, one per BOTH_MODE 0..3,
// plus one with INIT=1 (all ones) and an out-of-range mode. All share the
// same stimulus and are checked every edge against a reference model.
module tb_srff_cell;

    localparam int NDUT = 5;

    logic       clk = 1'b0;
    logic       clrn_drv;
    logic       prn_drv;
    logic       ena_drv;
    logic [3:0] s_drv;
    logic [3:0] r_drv;
    logic [3:0] q_obs [NDUT];

    logic [3:0] m_q    [NDUT];
    int         m_mode [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // One instance per legal BOTH_MODE.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        srff_cell_if #(.WIDTH(4)) bus ();
        assign bus.prn = prn_drv;
        assign bus.ena = ena_drv;
        assign bus.s   = s_drv;
        assign bus.r   = r_drv;
        srff_cell #(.WIDTH(4), .INIT(64'd0), .BOTH_MODE(gi)) dut (
            .clk  (clk),
            .clrn (clrn_drv),
            .bus  (bus.slave)
        );
        assign q_obs[gi] = bus.q;
    end

    // Replicated power-up value and an out-of-range mode (must hold).
    srff_cell_if #(.WIDTH(4)) bus_x ();
    assign bus_x.prn = prn_drv;
    assign bus_x.ena = ena_drv;
    assign bus_x.s   = s_drv;
    assign bus_x.r   = r_drv;
    srff_cell #(.WIDTH(4), .INIT(64'd1), .BOTH_MODE(5)) dut_x (
        .clk  (clk),
        .clrn (clrn_drv),
        .bus  (bus_x.slave)
    );
    assign q_obs[4] = bus_x.q;

    // Reference next state, written from the rules as whole-vector arithmetic.
    function automatic logic [3:0] model_next(input logic [3:0] q, input int mode,
                                              input logic clrn, input logic prn,
                                              input logic ena, input logic [3:0] s,
                                              input logic [3:0] r);
        logic [3:0] both, set_only, clr_only, nq;
        if (!clrn) return 4'b0000;
        if (!prn)  return 4'b1111;
        if (!ena)  return q;
        both     = s & r;
        set_only = s & ~r;
        clr_only = r & ~s;
        nq       = (q | set_only) & ~clr_only;
        case (mode)
            1:       nq = nq | both;
            2:       nq = nq & ~both;
            3:       nq = nq ^ both;
            default: nq = nq;
        endcase
        return nq;
    endfunction

    // Advance one clock edge with the currently driven inputs; model follows.
    task automatic tick();
        logic [3:0] nxt [NDUT];
        for (int k = 0; k < NDUT; k++)
            nxt[k] = model_next(m_q[k], m_mode[k], clrn_drv, prn_drv, ena_drv, s_drv, r_drv);
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) m_q[k] = nxt[k];
    endtask

    task automatic idle_inputs();
        clrn_drv = 1'b1; prn_drv = 1'b1; ena_drv = 1'b1; s_drv = 4'b0; r_drv = 4'b0;
    endtask

    task automatic clear_all();
        idle_inputs();
        clrn_drv = 1'b0;
        tick();
        clrn_drv = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (q_obs[k] !== m_q[k]) begin
                n_fail++;
                $display("FAIL powerup dut%0d: q=%b expected %b", k, q_obs[k], m_q[k]);
            end
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (q_obs[k] !== m_q[k]) begin
                    n_fail++;
                    $display("FAIL idle_hold dut%0d cyc%0d: q=%b expected %b", k, c, q_obs[k], m_q[k]);
                end
            end
        end
        n_checks++;
        if (q_obs[4] !== 4'b1111) begin
            n_fail++;
            $display("FAIL init_replicate: q=%b expected 1111", q_obs[4]);
        end
        $display("test_reset done, q0=%b qx=%b", q_obs[0], q_obs[4]);
    endtask

    task automatic test_pulse_capture();
        clear_all();
        s_drv = 4'b0001;
        tick();
        s_drv = 4'b0000;
        for (int c = 0; c < 11; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (q_obs[k] !== m_q[k]) begin
                    n_fail++;
                    $display("FAIL pulse_hold dut%0d cyc%0d: q=%b expected %b", k, c, q_obs[k], m_q[k]);
                end
            end
            if (c < 10) tick();
        end
        n_checks++;
        if (q_obs[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL pulse_latched: q=%b expected 0001", q_obs[0]);
        end
        r_drv = 4'b0001;
        tick();
        r_drv = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (q_obs[k] !== m_q[k]) begin
                    n_fail++;
                    $display("FAIL pulse_release dut%0d cyc%0d: q=%b expected %b", k, c, q_obs[k], m_q[k]);
                end
            end
            tick();
        end
        $display("test_pulse_capture done, q0=%b", q_obs[0]);
    endtask

    task automatic test_both_mode();
        // From q=0 and from q=1: one cycle of s=r=1.
        for (int start = 0; start < 2; start++) begin
            clear_all();
            if (start == 1) begin
                s_drv = 4'b1111;
                tick();
            end
            s_drv = 4'b1111; r_drv = 4'b1111;
            tick();
            idle_inputs();
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (q_obs[k] !== m_q[k]) begin
                    n_fail++;
                    $display("FAIL both_from%0d dut%0d: q=%b expected %b", start, k, q_obs[k], m_q[k]);
                end
            end
        end
        // Held s=r=1: mode 3 toggles on every edge.
        clear_all();
        s_drv = 4'b1111; r_drv = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (q_obs[k] !== m_q[k]) begin
                    n_fail++;
                    $display("FAIL both_held dut%0d cyc%0d: q=%b expected %b", k, c, q_obs[k], m_q[k]);
                end
            end
            n_checks++;
            if (q_obs[3] !== ((c % 2 == 0) ? 4'b1111 : 4'b0000)) begin
                n_fail++;
                $display("FAIL toggle_seq cyc%0d: q=%b expected %b", c, q_obs[3],
                         (c % 2 == 0) ? 4'b1111 : 4'b0000);
            end
        end
        idle_inputs();
        $display("test_both_mode done, q=%b %b %b %b %b", q_obs[0], q_obs[1], q_obs[2], q_obs[3], q_obs[4]);
    endtask

    task automatic test_priority();
        clear_all();
        s_drv = 4'b1111;
        tick();
        clrn_drv = 1'b0; prn_drv = 1'b0; s_drv = 4'b1111;
        tick();
        n_checks++;
        if (q_obs[0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_over_all: q=%b expected 0000", q_obs[0]);
        end
        clrn_drv = 1'b1; prn_drv = 1'b0; s_drv = 4'b0000; r_drv = 4'b1111;
        tick();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (q_obs[k] !== m_q[k]) begin
                n_fail++;
                $display("FAIL prn_over_r dut%0d: q=%b expected %b", k, q_obs[k], m_q[k]);
            end
        end
        idle_inputs();
        // clrn low between edges only: no effect now or at the next edge.
        clrn_drv = 1'b0;
        #1;
        n_checks++;
        if (q_obs[0] !== m_q[0]) begin
            n_fail++;
            $display("FAIL glitch_comb: q=%b expected %b", q_obs[0], m_q[0]);
        end
        #2;
        clrn_drv = 1'b1;
        tick();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (q_obs[k] !== 4'b1111) begin
                n_fail++;
                $display("FAIL clr_glitch dut%0d: q=%b expected 1111", k, q_obs[k]);
            end
        end
        $display("test_priority done, q0=%b", q_obs[0]);
    endtask

    task automatic test_enable();
        clear_all();
        ena_drv = 1'b0; s_drv = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (q_obs[0] !== 4'b0000) begin
                n_fail++;
                $display("FAIL ena_hold cyc%0d: q=%b expected 0000", c, q_obs[0]);
            end
        end
        ena_drv = 1'b1;
        tick();
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (q_obs[k] !== m_q[k]) begin
                n_fail++;
                $display("FAIL ena_rise dut%0d: q=%b expected %b", k, q_obs[k], m_q[k]);
            end
        end
        idle_inputs();
        $display("test_enable done, q0=%b", q_obs[0]);
    endtask

    task automatic test_width();
        clear_all();
        s_drv = 4'b1000;
        tick();
        s_drv = 4'b0101; r_drv = 4'b1000;
        tick();
        n_checks++;
        if (q_obs[0] !== 4'b0101) begin
            n_fail++;
            $display("FAIL width_step1: q=%b expected 0101", q_obs[0]);
        end
        s_drv = 4'b0010; r_drv = 4'b0001;
        tick();
        n_checks++;
        if (q_obs[0] !== 4'b0110) begin
            n_fail++;
            $display("FAIL width_step2: q=%b expected 0110", q_obs[0]);
        end
        for (int k = 0; k < NDUT; k++) begin
            n_checks++;
            if (q_obs[k] !== m_q[k]) begin
                n_fail++;
                $display("FAIL width_model dut%0d: q=%b expected %b", k, q_obs[k], m_q[k]);
            end
        end
        idle_inputs();
        $display("test_width done, q0=%b", q_obs[0]);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        for (int c = 0; c < 400; c++) begin
            s_drv    = 4'($urandom);
            r_drv    = 4'($urandom);
            ena_drv  = ($urandom_range(0, 5) != 0);
            prn_drv  = ($urandom_range(0, 15) != 0);
            clrn_drv = ($urandom_range(0, 19) != 0);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                n_checks++;
                if (q_obs[k] !== m_q[k]) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: q=%b expected %b (s=%b r=%b ena=%b prn=%b clrn=%b)",
                             k, c, q_obs[k], m_q[k], s_drv, r_drv, ena_drv, prn_drv, clrn_drv);
                end
            end
        end
        idle_inputs();
        $display("test_random done, %0d new failures", n_fail - errs_before);
    endtask

    initial begin
        m_mode = '{0, 1, 2, 3, 5};
        m_q    = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
        idle_inputs();
        #1;
        test_reset();
        test_pulse_capture();
        test_both_mode();
        test_priority();
        test_enable();
        test_width();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
